dmem_arbiter: RTL and testbench

Two-requester access controller for the 512 x 32 data memory.
- Shares the single-port memory between the CPU memory stage (port C) and the host/loader DMA (port H): one access per cycle.
- CPU has fixed priority; a wait counter bounds host starvation.
- Reads return through a registered response path; the block drives the memory's addr/data_in/wr_en and samples its asynchronous read output.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/data_memory.sv | 27 ++
 rtl/dmem_subsystem.sv | 75 +++++++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory access controller.
package dmem_pkg;

    localparam int DMEM_CAPACITY   = 512;
    localparam int DMEM_BUS_WIDTH  = 32;
    localparam int DMEM_ADDR_WIDTH = 9;
    localparam int DMEM_MAX_WAIT   = 4;

    // Arbitration policy: CPU-first normally, one forced host cycle after starvation
    typedef enum logic {
        PRI_CPU,
        PRI_HOST
    } arb_state_t;

    // Identity of the requester that owns the memory this cycle
    typedef enum logic {
        REQ_CPU,
        REQ_HOST
    } req_id_t;

endpackage

// File: rtl/data_memory.sv
// Single-port word memory: synchronous write, asynchronous read.
module data_memory
    import dmem_pkg::*;
#(
    parameter int CAPACITY   = DMEM_CAPACITY,
    parameter int BUS_WIDTH  = DMEM_BUS_WIDTH,
    parameter int ADDR_WIDTH = $clog2(CAPACITY)
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BUS_WIDTH-1:0]  data_in,
    input  logic                  wr_en,
    output logic [BUS_WIDTH-1:0]  data_out
);

    logic [BUS_WIDTH-1:0] mem [CAPACITY];

    // Commit a write at the edge that closes the access cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= data_in;
        end
    end

    assign data_out = mem[addr];

endmodule

// File: rtl/dmem_subsystem.sv
// Integration wrapper: arbiter in front of the single-port data memory.
module dmem_subsystem
    import dmem_pkg::*;
#(
    parameter int CAPACITY   = DMEM_CAPACITY,
    parameter int BUS_WIDTH  = DMEM_BUS_WIDTH,
    parameter int ADDR_WIDTH = $clog2(CAPACITY),
    parameter int MAX_WAIT   = DMEM_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [BUS_WIDTH-1:0]  c_wdata,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [BUS_WIDTH-1:0]  c_rdata,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [BUS_WIDTH-1:0]  h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [BUS_WIDTH-1:0]  h_rdata,
    output logic                  c_stall
);

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BUS_WIDTH-1:0]  mem_wdata;
    logic                  mem_we;
    logic [BUS_WIDTH-1:0]  mem_rdata;

    dmem_arbiter #(
        .CAPACITY  (CAPACITY),
        .BUS_WIDTH (BUS_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .MAX_WAIT  (MAX_WAIT)
    ) u_arbiter (
        .clk      (clk),
        .rst_n    (rst_n),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .h_req    (h_req),
        .h_we     (h_we),
        .h_addr   (h_addr),
        .h_wdata  (h_wdata),
        .h_gnt    (h_gnt),
        .h_rvalid (h_rvalid),
        .h_rdata  (h_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .c_stall  (c_stall)
    );

    data_memory #(
        .CAPACITY  (CAPACITY),
        .BUS_WIDTH (BUS_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_memory (
        .clk     (clk),
        .addr    (mem_addr),
        .data_in (mem_wdata),
        .wr_en   (mem_we),
        .data_out(mem_rdata)
    );

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU memory stage and the
// host DMA. The CPU has fixed priority; a wait counter forces one host grant
// after MAX_WAIT denied cycles so the host cannot starve.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int CAPACITY   = DMEM_CAPACITY,
    parameter int BUS_WIDTH  = DMEM_BUS_WIDTH,
    parameter int ADDR_WIDTH = $clog2(CAPACITY),
    parameter int MAX_WAIT   = DMEM_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [BUS_WIDTH-1:0]  c_wdata,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [BUS_WIDTH-1:0]  c_rdata,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [BUS_WIDTH-1:0]  h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [BUS_WIDTH-1:0]  h_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0]  mem_wdata,
    output logic                  mem_we,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    output logic                  c_stall
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
    localparam logic [3:0] WAIT_ARM   = 4'(MAX_WAIT - 1);

    arb_state_t      state;
    logic [3:0]      wait_cnt;
    logic            h_force;
    req_id_t         winner;

    // Grant decision; gating with rst_n keeps a write in flight at reset from committing
    always_comb begin
        h_force = h_req & (state == PRI_HOST) & (wait_cnt == WAIT_LIMIT);
        h_gnt   = rst_n & h_req & (h_force | ~c_req);
        c_gnt   = rst_n & c_req & ~h_gnt;
        c_stall = c_req & ~c_gnt;
        winner  = h_gnt ? REQ_HOST : REQ_CPU;
    end

    // Steer the winner onto the memory port; park the bus at zero when idle
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (c_gnt | h_gnt) begin
            if (winner == REQ_HOST) begin
                mem_addr  = h_addr;
                mem_wdata = h_wdata;
                mem_we    = h_we;
            end else begin
                mem_addr  = c_addr;
                mem_wdata = c_wdata;
                mem_we    = c_we;
            end
        end
    end

    // Policy FSM and host starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PRI_CPU;
            wait_cnt <= '0;
        end else begin
            if (!h_req || h_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            case (state)
                PRI_CPU: begin
                    if (h_req && !h_gnt && (wait_cnt == WAIT_ARM)) begin
                        state <= PRI_HOST;
                    end
                end
                PRI_HOST: begin
                    // One cycle only: either the forced grant happened or the host withdrew
                    state <= PRI_CPU;
                end
                default: state <= PRI_CPU;
            endcase
        end
    end

    // CPU read return: capture asynchronous memory output at the end of the grant cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rvalid <= 1'b0;
            c_rdata  <= '0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            if (c_gnt && !c_we) begin
                c_rdata <= mem_rdata;
            end
        end
    end

    // Host read return: same timing as the CPU path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_rvalid <= 1'b0;
            h_rdata  <= '0;
        end else begin
            h_rvalid <= h_gnt & ~h_we;
            if (h_gnt && !h_we) begin
                h_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a reference memory and read-return queues.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW = DMEM_ADDR_WIDTH;
    localparam int DW = DMEM_BUS_WIDTH;

    logic          clk;
    logic          rst_n;
    logic          c_req, c_we, h_req, h_we;
    logic [AW-1:0] c_addr, h_addr;
    logic [DW-1:0] c_wdata, h_wdata;
    logic          c_gnt, c_rvalid, h_gnt, h_rvalid, c_stall;
    logic [DW-1:0] c_rdata, h_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DMEM_CAPACITY];
    logic [DW-1:0] cq [$];
    logic [DW-1:0] hq [$];
    logic [DW-1:0] c_last;
    logic [DW-1:0] h_last;

    dmem_arbiter u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .h_req    (h_req),
        .h_we     (h_we),
        .h_addr   (h_addr),
        .h_wdata  (h_wdata),
        .h_gnt    (h_gnt),
        .h_rvalid (h_rvalid),
        .h_rdata  (h_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .c_stall  (c_stall)
    );

    data_memory u_mem (
        .clk     (clk),
        .addr    (mem_addr),
        .data_in (mem_wdata),
        .wr_en   (mem_we),
        .data_out(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, name, obs, exp);
        end
    endtask

    task automatic drive_c(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        c_req = req; c_we = we; c_addr = addr; c_wdata = wdata;
    endtask

    task automatic drive_h(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        h_req = req; h_we = we; h_addr = addr; h_wdata = wdata;
    endtask

    // One bus cycle: inputs already driven; check grants mid-cycle, read returns after the edge
    task automatic step(input string tag, input logic eg_c, input logic eg_h);
        logic          c_pend, h_pend;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_we;
        @(negedge clk);
        e_addr  = eg_c ? c_addr  : (eg_h ? h_addr  : '0);
        e_wdata = eg_c ? c_wdata : (eg_h ? h_wdata : '0);
        e_we    = (eg_c & c_we) | (eg_h & h_we);
        chk(tag, "c_gnt",     DW'(c_gnt),   DW'(eg_c));
        chk(tag, "h_gnt",     DW'(h_gnt),   DW'(eg_h));
        chk(tag, "c_stall",   DW'(c_stall), DW'(c_req & ~eg_c));
        chk(tag, "mem_we",    DW'(mem_we),  DW'(e_we));
        chk(tag, "mem_addr",  DW'(mem_addr), DW'(e_addr));
        chk(tag, "mem_wdata", mem_wdata,    e_wdata);
        c_pend = eg_c & ~c_we;
        h_pend = eg_h & ~h_we;
        if (c_pend) cq.push_back(ref_mem[c_addr]);
        if (h_pend) hq.push_back(ref_mem[h_addr]);
        if (eg_c && c_we) ref_mem[c_addr] = c_wdata;
        if (eg_h && h_we) ref_mem[h_addr] = h_wdata;
        @(posedge clk);
        #1;
        chk(tag, "c_rvalid", DW'(c_rvalid), DW'(c_pend));
        chk(tag, "h_rvalid", DW'(h_rvalid), DW'(h_pend));
        if (c_rvalid === 1'b1) begin
            checks++;
            assert (cq.size() > 0) else begin
                errors++;
                $error("FAIL %s/c_queue: observed rvalid with no read outstanding, expected none", tag);
            end
            if (cq.size() > 0) c_last = cq.pop_front();
        end
        if (h_rvalid === 1'b1) begin
            checks++;
            assert (hq.size() > 0) else begin
                errors++;
                $error("FAIL %s/h_queue: observed rvalid with no read outstanding, expected none", tag);
            end
            if (hq.size() > 0) h_last = hq.pop_front();
        end
        chk(tag, "c_rdata", c_rdata, c_last);
        chk(tag, "h_rdata", h_rdata, h_last);
    endtask

    initial begin
        c_last = '0;
        h_last = '0;
        rst_n  = 1'b0;
        drive_c(1'b1, 1'b1, 9'h010, 32'hDEADBEEF);
        drive_h(1'b1, 1'b0, 9'h007, '0);
        #1;
        chk("reset", "c_gnt",    DW'(c_gnt),    '0);
        chk("reset", "h_gnt",    DW'(h_gnt),    '0);
        chk("reset", "mem_we",   DW'(mem_we),   '0);
        chk("reset", "c_rvalid", DW'(c_rvalid), '0);
        chk("reset", "h_rvalid", DW'(h_rvalid), '0);
        chk("reset", "c_rdata",  c_rdata,       '0);
        chk("reset", "h_rdata",  h_rdata,       '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_c(1'b0, 1'b0, '0, '0);
        drive_h(1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;

        // Preload the addresses the later tests read
        drive_c(1'b1, 1'b1, 9'h010, 32'h1111_0010); step("pre_010", 1'b1, 1'b0);
        drive_c(1'b1, 1'b1, 9'h011, 32'h2222_0011); step("pre_011", 1'b1, 1'b0);
        drive_c(1'b1, 1'b1, 9'h005, 32'h5555_0005); step("pre_005", 1'b1, 1'b0);
        drive_c(1'b0, 1'b0, '0, '0);
        drive_h(1'b1, 1'b1, 9'h007, 32'h7777_0007); step("pre_007", 1'b0, 1'b1);
        drive_h(1'b0, 1'b0, '0, '0);
        drive_c(1'b1, 1'b0, 9'h011, '0);            step("pre_rd011", 1'b1, 1'b0);

        // Reset asserted in the middle of a CPU write cycle
        drive_c(1'b1, 1'b1, 9'h010, 32'hDEADBEEF);
        drive_h(1'b1, 1'b0, 9'h007, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst", "c_gnt",    DW'(c_gnt),    '0);
        chk("midrst", "h_gnt",    DW'(h_gnt),    '0);
        chk("midrst", "mem_we",   DW'(mem_we),   '0);
        chk("midrst", "c_rvalid", DW'(c_rvalid), '0);
        chk("midrst", "h_rvalid", DW'(h_rvalid), '0);
        chk("midrst", "c_rdata",  c_rdata,       '0);
        chk("midrst", "h_rdata",  h_rdata,       '0);
        cq.delete();
        hq.delete();
        c_last = '0;
        h_last = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_c(1'b0, 1'b0, '0, '0);
        drive_h(1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        drive_c(1'b1, 1'b0, 9'h010, '0);            step("rst_rd010", 1'b1, 1'b0);
        drive_c(1'b0, 1'b0, '0, '0);                step("rst_idle", 1'b0, 1'b0);

        // CPU write then immediate read-back
        drive_c(1'b1, 1'b1, 9'h1A5, 32'h12345678);  step("cpu_wr", 1'b1, 1'b0);
        drive_c(1'b1, 1'b0, 9'h1A5, '0);            step("cpu_rd", 1'b1, 1'b0);
        drive_c(1'b0, 1'b0, '0, '0);                step("cpu_idle", 1'b0, 1'b0);

        // Host alone: back-to-back writes then reads
        for (int i = 0; i < 4; i++) begin
            drive_h(1'b1, 1'b1, AW'(i), DW'(32'hA0 + i));
            step("host_wr", 1'b0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            drive_h(1'b1, 1'b0, AW'(i), '0);
            step("host_rd", 1'b0, 1'b1);
        end
        drive_h(1'b0, 1'b0, '0, '0);                step("host_idle", 1'b0, 1'b0);

        // Contention: host forced in its fifth request cycle
        drive_c(1'b1, 1'b0, 9'h005, '0);
        drive_h(1'b1, 1'b0, 9'h007, '0);
        for (int k = 0; k < 4; k++) step("cont_cpu", 1'b1, 1'b0);
        step("cont_force", 1'b0, 1'b1);
        drive_h(1'b0, 1'b0, '0, '0);                step("cont_resume", 1'b1, 1'b0);
        drive_c(1'b0, 1'b0, '0, '0);                step("cont_idle", 1'b0, 1'b0);

        // Host withdraws at wait_cnt=3: count restarts from zero
        drive_c(1'b1, 1'b0, 9'h005, '0);
        drive_h(1'b1, 1'b0, 9'h007, '0);
        for (int k = 0; k < 3; k++) step("drop_wait", 1'b1, 1'b0);
        drive_h(1'b0, 1'b0, '0, '0);                step("drop_gap", 1'b1, 1'b0);
        drive_h(1'b1, 1'b0, 9'h007, '0);
        for (int k = 0; k < 4; k++) step("drop_rewait", 1'b1, 1'b0);
        step("drop_force", 1'b0, 1'b1);
        drive_h(1'b0, 1'b0, '0, '0);                step("drop_resume", 1'b1, 1'b0);
        drive_c(1'b0, 1'b0, '0, '0);                step("drop_idle", 1'b0, 1'b0);

        // Simultaneous writes to one address: CPU first, host last
        drive_c(1'b1, 1'b1, 9'h020, 32'h1);
        drive_h(1'b1, 1'b1, 9'h020, 32'h2);         step("same_cpu", 1'b1, 1'b0);
        drive_c(1'b0, 1'b0, '0, '0);                step("same_host", 1'b0, 1'b1);
        drive_h(1'b0, 1'b0, '0, '0);
        drive_c(1'b1, 1'b0, 9'h020, '0);            step("same_rd", 1'b1, 1'b0);
        drive_c(1'b0, 1'b0, '0, '0);                step("same_idle", 1'b0, 1'b0);
        chk("same_final", "c_rdata", c_rdata, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
